// File: rtl/vec_issue_unit.sv
// vec_issue_unit: instruction FIFO and micro-op sequencer feeding the vector coprocessor (define VEC_ISSUE_GROUP_EN to honour the grp field)
module vec_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [31:0]               in_scalar,
  input  logic                      flush,
  output logic                      vec_we,
  output logic [2:0]                vec_addr_rd,
  output logic [2:0]                vec_addr_rs,
  output logic [2:0]                vec_addr_rt,
  output logic [3:0]                aluOp,
  output logic [4:0]                shamt,
  output logic                      useSign,
  output logic [31:0]               scalar_val,
  output logic                      use_scalar,
  output logic                      uop_valid,
  input  logic                      vec_zero,
  output logic                      zero_valid,
  output logic                      zero_flag,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [63:0] head;
  logic [31:0] hi;
  logic push, pop, full, empty, done, last, acc;
  assign full = fifo_count == CW'(DEPTH);
  assign empty = fifo_count == '0;
  assign in_ready = !full && !flush;
  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];
  assign hi = head[63:32];
  assign done = state == ISSUE && last;
`ifdef VEC_ISSUE_GROUP_EN
  logic [2:0] cnt;
  logic unused;
  assign last = cnt == 3'd0;
  assign unused = ^hi[7:0];
  // micro-ops still to issue after the current one
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (flush) cnt <= '0;
    else if (pop) cnt <= hi[10:8];
    else if (state == ISSUE && !last) cnt <= cnt - 3'd1;
`else
  logic unused;
  assign last = 1'b1;
  assign unused = ^hi[10:0];
`endif
  // pop when idle or finishing the last micro-op, so groups run back-to-back
  always_comb begin
    pop = !flush && !empty && (state == IDLE || done);
    state_n = flush ? IDLE : pop ? ISSUE : done ? IDLE : state;
  end
  // sequencer state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // FIFO storage, no reset needed since occupancy is tracked separately
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_instr, in_scalar};
  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
  // micro-op registers: load on pop, step register indices inside a group, clear when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {uop_valid, vec_we, vec_addr_rd, vec_addr_rs, vec_addr_rt, aluOp, shamt, useSign, scalar_val, use_scalar} <= '0;
    end else if (pop) begin
      uop_valid <= 1'b1;
      aluOp <= hi[31:28];
      vec_addr_rd <= hi[27:25];
      vec_addr_rs <= hi[24:22];
      vec_addr_rt <= hi[21:19];
      shamt <= hi[18:14];
      useSign <= hi[13];
      use_scalar <= hi[12];
      vec_we <= hi[11];
      scalar_val <= head[31:0];
    end else if (flush || done) begin
      {uop_valid, vec_we, vec_addr_rd, vec_addr_rs, vec_addr_rt, aluOp, shamt, useSign, scalar_val, use_scalar} <= '0;
    end
`ifdef VEC_ISSUE_GROUP_EN
    else if (state == ISSUE) begin
      vec_addr_rd <= vec_addr_rd + 3'd1;
      vec_addr_rs <= vec_addr_rs + 3'd1;
      vec_addr_rt <= vec_addr_rt + 3'd1;
    end
`endif
  end
  // zero accumulation per instruction and completion pulse; an aborted instruction reports nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b1;
      zero_valid <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      acc <= pop ? 1'b1 : (state == ISSUE ? acc & vec_zero : acc);
      zero_valid <= done && !flush;
      zero_flag <= done && !flush && acc && vec_zero;
    end
  end
endmodule

// File: tb/tb_vec_issue_unit.sv
// tb_vec_issue_unit: randomized and directed checks of vec_issue_unit against a queue-based model
module tb_vec_issue_unit;
  localparam int DEPTH = 4;
`ifdef VEC_ISSUE_GROUP_EN
  localparam int NU = 4;
  localparam bit GEN = 1'b1;
`else
  localparam int NU = 1;
  localparam bit GEN = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, vec_zero = 0;
  logic [31:0] in_instr = 0, in_scalar = 0;
  logic in_ready, vec_we, useSign, use_scalar, uop_valid, zero_valid, zero_flag;
  logic [2:0] vec_addr_rd, vec_addr_rs, vec_addr_rt;
  logic [3:0] aluOp;
  logic [4:0] shamt;
  logic [31:0] scalar_val;
  logic [$clog2(DEPTH):0] fifo_count;
  int n_chk = 0, n_fail = 0;
  vec_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_scalar(in_scalar), .flush(flush), .vec_we(vec_we), .vec_addr_rd(vec_addr_rd),
    .vec_addr_rs(vec_addr_rs), .vec_addr_rt(vec_addr_rt), .aluOp(aluOp), .shamt(shamt),
    .useSign(useSign), .scalar_val(scalar_val), .use_scalar(use_scalar), .uop_valid(uop_valid),
    .vec_zero(vec_zero), .zero_valid(zero_valid), .zero_flag(zero_flag), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mk(input int alu, input int rd, input int rs, input int rt,
                                     input int sh, input int us, input int usc, input int we, input int grp);
    return {alu[3:0], rd[2:0], rs[2:0], rt[2:0], sh[4:0], us[0], usc[0], we[0], grp[2:0], 8'hA5};
  endfunction
  function automatic int uops_of(input logic [63:0] e);
    return GEN ? int'(e[42:40]) + 1 : 1;
  endfunction
  // reference model: a queue of accepted instructions and the one being expanded
  logic [63:0] m_q[$];
  logic [63:0] m_cur = 0;
  bit m_busy = 0, m_acc = 1, m_zv = 0, m_zf = 0;
  int m_k = 0, m_n = 1;
  always @(posedge clk or posedge rst) begin
    bit push, nzv, nzf;
    if (rst) begin
      m_q.delete();
      m_busy = 0;
      m_zv = 0;
      m_zf = 0;
    end else begin
      push = in_valid && m_q.size() < DEPTH && !flush;
      nzv = 0;
      nzf = 0;
      if (flush) begin
        m_q.delete();
        m_busy = 0;
      end else begin
        if (m_busy) begin
          m_acc = m_acc & vec_zero;
          if (m_k == m_n - 1) begin
            nzv = 1;
            nzf = m_acc;
            m_busy = 0;
          end else m_k++;
        end
        if (!m_busy && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_busy = 1;
          m_k = 0;
          m_acc = 1;
          m_n = uops_of(m_cur);
        end
        if (push) m_q.push_back({in_instr, in_scalar});
      end
      m_zv = nzv;
      m_zf = nzf;
    end
  end
  // compare every output against the model each cycle, away from the clock edge
  always @(negedge clk) begin
    logic [31:0] ins;
    ins = m_cur[63:32];
    if (!rst) begin
      chk("uop_valid", 32'(uop_valid), 32'(m_busy));
      chk("vec_we", 32'(vec_we), m_busy ? 32'(ins[11]) : 32'd0);
      chk("aluOp", 32'(aluOp), m_busy ? 32'(ins[31:28]) : 32'd0);
      chk("rd", 32'(vec_addr_rd), m_busy ? 32'((int'(ins[27:25]) + m_k) % 8) : 32'd0);
      chk("rs", 32'(vec_addr_rs), m_busy ? 32'((int'(ins[24:22]) + m_k) % 8) : 32'd0);
      chk("rt", 32'(vec_addr_rt), m_busy ? 32'((int'(ins[21:19]) + m_k) % 8) : 32'd0);
      chk("shamt", 32'(shamt), m_busy ? 32'(ins[18:14]) : 32'd0);
      chk("useSign", 32'(useSign), m_busy ? 32'(ins[13]) : 32'd0);
      chk("use_scalar", 32'(use_scalar), m_busy ? 32'(ins[12]) : 32'd0);
      chk("scalar_val", scalar_val, m_busy ? m_cur[31:0] : 32'd0);
      chk("zero_valid", 32'(zero_valid), 32'(m_zv));
      if (m_zv) chk("zero_flag", 32'(zero_flag), 32'(m_zf));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH && !flush));
    end
  end
  task automatic drain();
    @(negedge clk);
    #1 in_valid = 0; flush = 0; vec_zero = 1;
    repeat (40) @(negedge clk);
  endtask
  task automatic offer(input logic [31:0] ins, input logic [31:0] sc);
    @(negedge clk);
    #1 in_valid = 1; in_instr = ins; in_scalar = sc;
  endtask
  task automatic group_run(input logic [3:0] zpat, input bit exp_flag);
    offer(mk(5, 6, 7, 0, 9, 1, 1, 1, 3), 32'hDEADBEEF);
    @(negedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      chk("g_uop_valid", 32'(uop_valid), 32'd1);
      chk("g_rd", 32'(vec_addr_rd), 32'((6 + i) % 8));
      chk("g_rs", 32'(vec_addr_rs), 32'((7 + i) % 8));
      chk("g_rt", 32'(vec_addr_rt), 32'(i));
      chk("g_scalar", scalar_val, 32'hDEADBEEF);
      #1 vec_zero = zpat[i];
      @(negedge clk);
    end
    chk("g_zero_valid", 32'(zero_valid), 32'd1);
    chk("g_zero_flag", 32'(zero_flag), 32'(exp_flag));
    chk("g_uop_done", 32'(uop_valid), 32'd0);
  endtask
  initial begin
    int gaps;
    bit saw_full;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_uop_valid", 32'(uop_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_zero_valid", 32'(zero_valid), 32'd0);
    chk("rst_zero_flag", 32'(zero_flag), 32'd0);
    // single instruction: two-cycle latency, one micro-op, completion pulse
    #1 in_valid = 1; in_instr = mk(2, 1, 2, 3, 0, 0, 0, 1, 0); in_scalar = 32'h1234; vec_zero = 1;
    @(negedge clk);
    chk("s1_count", 32'(fifo_count), 32'd1);
    chk("s1_uop", 32'(uop_valid), 32'd0);
    #1 in_valid = 0;
    @(negedge clk);
    chk("s2_uop", 32'(uop_valid), 32'd1);
    chk("s2_we", 32'(vec_we), 32'd1);
    chk("s2_aluOp", 32'(aluOp), 32'd2);
    chk("s2_addrs", {29'd0, vec_addr_rd} * 100 + {29'd0, vec_addr_rs} * 10 + {29'd0, vec_addr_rt}, 32'd123);
    @(negedge clk);
    chk("s3_zero_valid", 32'(zero_valid), 32'd1);
    chk("s3_zero_flag", 32'(zero_flag), 32'd1);
    chk("s3_uop", 32'(uop_valid), 32'd0);
    @(negedge clk);
    chk("s4_zero_valid", 32'(zero_valid), 32'd0);
    // grouped instruction with index wrap and zero accumulation
    drain();
    group_run(4'b1011, !GEN);
    drain();
    group_run(4'b1111, 1'b1);
    // held offer of long groups: FIFO fills and micro-ops never stall
    drain();
    gaps = 0;
    saw_full = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c > 2 && !uop_valid) gaps++;
      if (!in_ready && fifo_count == DEPTH) saw_full = 1;
      #1 in_valid = 1; in_instr = mk(c, c, c + 1, c + 2, c, 0, 1, 1, 7); in_scalar = 32'(c);
    end
    chk("full_no_gap", 32'(gaps), 32'd0);
`ifdef VEC_ISSUE_GROUP_EN
    chk("full_seen", 32'(saw_full), 32'd1);
`endif
    // flush during the second micro-op with work queued and an instruction offered
    drain();
    offer(mk(3, 1, 1, 1, 0, 0, 0, 1, 3), 32'hA);
    offer(mk(4, 2, 2, 2, 0, 0, 0, 1, 3), 32'hB);
    offer(mk(6, 3, 3, 3, 0, 0, 0, 1, 3), 32'hC);
    @(negedge clk);
    chk("f_uop_before", 32'(uop_valid), 32'd1);
    #1 in_instr = mk(7, 4, 4, 4, 0, 0, 0, 1, 0); flush = 1;
    #1 chk("f_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("f_uop", 32'(uop_valid), 32'd0);
    chk("f_count", 32'(fifo_count), 32'd0);
    chk("f_zero_valid", 32'(zero_valid), 32'd0);
    chk("f_we", 32'(vec_we), 32'd0);
    #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("f_zero_valid2", 32'(zero_valid), 32'd0);
    // asynchronous reset mid-group, then normal latency after release
    drain();
    offer(mk(9, 5, 5, 5, 3, 1, 1, 1, 3), 32'h55);
    offer(mk(8, 1, 1, 1, 0, 0, 0, 1, 1), 32'h66);
    @(negedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    #1 rst = 1;
    #1 chk("r_uop", 32'(uop_valid), 32'd0);
    chk("r_in_ready", 32'(in_ready), 32'd1);
    chk("r_count", 32'(fifo_count), 32'd0);
    chk("r_we", 32'(vec_we), 32'd0);
    chk("r_aluOp", 32'(aluOp), 32'd0);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("r_zero_valid", 32'(zero_valid), 32'd0);
    #1 in_valid = 1; in_instr = mk(1, 4, 0, 2, 0, 0, 0, 1, 0); in_scalar = 32'h77;
    @(negedge clk);
    chk("r1_uop", 32'(uop_valid), 32'd0);
    #1 in_valid = 0;
    @(negedge clk);
    chk("r2_uop", 32'(uop_valid), 32'd1);
    chk("r2_rd", 32'(vec_addr_rd), 32'd4);
    // randomized traffic with alternating offer rates and occasional flush
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      in_valid = $urandom_range(0, 99) < (((c / 500) % 2) ? 15 : 70);
      in_instr = $urandom;
      in_scalar = $urandom;
      vec_zero = $urandom_range(0, 9) < 8;
      flush = $urandom_range(0, 99) < 2;
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
